// File: rtl/mul_div_pkg.sv
// Shared encodings for the RV32M multiply/divide unit: funct3 opcodes, FSM states
// and small sign-handling helpers used by the decode and datapath.
package mul_div_pkg;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  // Step counter value seen during the 32nd (final) iteration.
  localparam logic [5:0] LAST_STEP = 6'd31;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_MUL  = 2'b01,
    ST_DIV  = 2'b10,
    ST_DONE = 2'b11
  } state_e;

  function automatic logic [31:0] cond_neg32(input logic [31:0] v, input logic neg);
    if (neg) begin
      cond_neg32 = 32'd0 - v;
    end else begin
      cond_neg32 = v;
    end
  endfunction

  function automatic logic [63:0] cond_neg64(input logic [63:0] v, input logic neg);
    if (neg) begin
      cond_neg64 = 64'd0 - v;
    end else begin
      cond_neg64 = v;
    end
  endfunction

  function automatic logic op_a_signed(input logic [2:0] f3);
    return (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

  function automatic logic op_b_signed(input logic [2:0] f3);
    return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

endpackage

// File: rtl/mul_div_core_div.sv
// Unsigned restoring divider datapath: one shift/subtract step per cycle on magnitudes.
// Next-step values are exposed so the owner can capture the final result on the last step.
module mul_div_core_div
  import mul_div_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_load,
  input  logic        i_step,
  input  logic [31:0] i_dividend,
  input  logic [31:0] i_divisor,
  output logic [31:0] o_quo_next,
  output logic [31:0] o_rem_next
);

  logic [31:0] r_rem;
  logic [31:0] r_quo;
  logic [31:0] r_dvsr;
  logic [32:0] w_shift;
  logic [31:0] w_sub;
  logic        w_fits;

  // r_quo holds the not-yet-consumed dividend bits at the top and new quotient bits at the bottom.
  assign w_shift = {r_rem, r_quo[31]};
  assign w_fits  = (w_shift >= {1'b0, r_dvsr});
  assign w_sub   = w_shift[31:0] - r_dvsr;

  // Select restored or subtracted partial remainder for this step.
  always_comb begin
    o_rem_next = w_shift[31:0];
    o_quo_next = {r_quo[30:0], 1'b0};
    if (w_fits) begin
      o_rem_next = w_sub;
      o_quo_next = {r_quo[30:0], 1'b1};
    end else begin
      o_rem_next = w_shift[31:0];
      o_quo_next = {r_quo[30:0], 1'b0};
    end
  end

  // Working registers: load operands on accept, advance one step per divide cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rem  <= 32'd0;
      r_quo  <= 32'd0;
      r_dvsr <= 32'd0;
    end else if (i_load) begin
      r_rem  <= 32'd0;
      r_quo  <= i_dividend;
      r_dvsr <= i_divisor;
    end else if (i_step) begin
      r_rem  <= o_rem_next;
      r_quo  <= o_quo_next;
    end else begin
      r_rem  <= r_rem;
      r_quo  <= r_quo;
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// RV32M multiply/divide unit: FSM, sign handling, shift-add multiplier and result register.
// Division iterations are delegated to mul_div_core_div.
module mul_div_unit
  import mul_div_pkg::*;
#(
  parameter int FAST_MUL = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  funct3,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  state_e      r_state;
  state_e      w_next_state;
  logic        r_busy;
  logic        r_done;
  logic [31:0] r_result;
  logic [5:0]  r_cnt;
  logic [2:0]  r_funct3;
  logic        r_neg_q;
  logic        r_neg_r;
  logic [63:0] r_acc;
  logic [31:0] r_mcand;

  logic        w_accept;
  logic        w_in_is_div;
  logic        w_in_sa;
  logic        w_in_sb;
  logic        w_div_zero;
  logic        w_div_ovf;
  logic        w_fast_path;
  logic        w_last_step;
  logic        w_busy_next;
  logic        w_done_next;
  logic [31:0] w_mag_a;
  logic [31:0] w_mag_b;
  logic [31:0] w_fast_result;
  logic [31:0] w_iter_result;
  logic [31:0] w_quo_next;
  logic [31:0] w_rem_next;
  logic [63:0] w_fast_prod;
  logic [63:0] w_acc_next;
  logic [63:0] w_iter_prod;
  logic [32:0] w_acc_sum;

  assign w_accept    = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_in_is_div = funct3[2];
  assign w_in_sa     = op_a_signed(funct3) && op_a[31];
  assign w_in_sb     = op_b_signed(funct3) && op_b[31];
  assign w_mag_a     = cond_neg32(op_a, w_in_sa);
  assign w_mag_b     = cond_neg32(op_b, w_in_sb);
  assign w_div_zero  = (op_b == 32'd0);
  assign w_div_ovf   = ((funct3 == F3_DIV) || (funct3 == F3_REM)) &&
                       (op_a == 32'h8000_0000) && (op_b == 32'hFFFF_FFFF);
  assign w_fast_prod = cond_neg64({32'd0, w_mag_a} * {32'd0, w_mag_b}, w_in_sa ^ w_in_sb);
  assign w_fast_path = w_in_is_div ? (w_div_zero || w_div_ovf) : (FAST_MUL != 0);
  assign w_last_step = (r_cnt == LAST_STEP);

  // Shift-add step: low half of r_acc starts as the multiplier and is consumed LSB first.
  assign w_acc_sum   = r_acc[0] ? ({1'b0, r_acc[63:32]} + {1'b0, r_mcand}) : {1'b0, r_acc[63:32]};
  assign w_acc_next  = {w_acc_sum, r_acc[31:1]};
  assign w_iter_prod = cond_neg64(w_acc_next, r_neg_q);

  mul_div_core_div u_core_div (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_accept && w_in_is_div),
    .i_step     (r_state == ST_DIV),
    .i_dividend (w_mag_a),
    .i_divisor  (w_mag_b),
    .o_quo_next (w_quo_next),
    .o_rem_next (w_rem_next)
  );

  // Result for operations that complete in the accepting cycle.
  always_comb begin
    w_fast_result = 32'd0;
    if (w_in_is_div) begin
      if (w_div_zero) begin
        w_fast_result = funct3[1] ? op_a : 32'hFFFF_FFFF;
      end else if (w_div_ovf) begin
        w_fast_result = funct3[1] ? 32'd0 : 32'h8000_0000;
      end else begin
        w_fast_result = 32'd0;
      end
    end else if (funct3 == F3_MUL) begin
      w_fast_result = w_fast_prod[31:0];
    end else begin
      w_fast_result = w_fast_prod[63:32];
    end
  end

  // Result of the iterative path, valid during the final step.
  always_comb begin
    w_iter_result = 32'd0;
    if (r_state == ST_DIV) begin
      if (r_funct3[1]) begin
        w_iter_result = cond_neg32(w_rem_next, r_neg_r);
      end else begin
        w_iter_result = cond_neg32(w_quo_next, r_neg_q);
      end
    end else if (r_funct3 == F3_MUL) begin
      w_iter_result = w_iter_prod[31:0];
    end else begin
      w_iter_result = w_iter_prod[63:32];
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // FSM next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (w_accept) begin
          if (w_fast_path) begin
            w_next_state = ST_DONE;
          end else if (w_in_is_div) begin
            w_next_state = ST_DIV;
          end else begin
            w_next_state = ST_MUL;
          end
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_MUL, ST_DIV: begin
        if (w_last_step) begin
          w_next_state = ST_DONE;
        end else begin
          w_next_state = r_state;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // FSM output decode, taken from the next state so busy/done can be registered.
  always_comb begin
    w_busy_next = (w_next_state == ST_MUL) || (w_next_state == ST_DIV);
    w_done_next = (w_next_state == ST_DONE);
  end

  // Registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_busy <= w_busy_next;
      r_done <= w_done_next;
    end
  end

  // Operand magnitudes, sign flags and step counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_funct3 <= 3'd0;
      r_cnt    <= 6'd0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_acc    <= 64'd0;
      r_mcand  <= 32'd0;
    end else if (w_accept) begin
      r_funct3 <= funct3;
      r_cnt    <= 6'd0;
      r_neg_q  <= w_in_sa ^ w_in_sb;
      r_neg_r  <= w_in_sa;
      r_acc    <= {32'd0, w_mag_b};
      r_mcand  <= w_mag_a;
    end else if (r_state == ST_MUL) begin
      r_acc    <= w_acc_next;
      r_cnt    <= r_cnt + 6'd1;
    end else if (r_state == ST_DIV) begin
      r_cnt    <= r_cnt + 6'd1;
    end else begin
      r_cnt    <= r_cnt;
    end
  end

  // Result register: written only on entry to DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_result <= 32'd0;
    end else if (w_accept && w_fast_path) begin
      r_result <= w_fast_result;
    end else if (((r_state == ST_MUL) || (r_state == ST_DIV)) && w_last_step) begin
      r_result <= w_iter_result;
    end else begin
      r_result <= r_result;
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign result = r_result;

endmodule
